// File: rtl/hawk_axird_arb_pkg.sv
// Shared types and helpers for the hawk N-master AXI4 read arbiter.
package hacd_pkg;

  // Arbitration mode as driven on prio_mode_i.
  typedef enum logic {
    HAWK_ARB_RR   = 1'b0,
    HAWK_ARB_PRIO = 1'b1
  } hawk_arb_mode_e;

  localparam int HAWK_ARB_MAX_MSTR = 8;
  // Outstanding-burst counter width; MAX_OUTSTD is capped at 15 so it always fits.
  localparam int HAWK_ARB_CNT_W    = 4;

  // AR payload at the default configuration (ID_W=4 plus up to 3 tag bits, 64-bit address).
  typedef struct packed {
    logic [6:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
  } hawk_arb_ar_t;

  // Single-step modulo: v is always below 2*n at every call site.
  function automatic int hawk_arb_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/hawk_axird_arb_if.sv
// AR/R bus bundle for the arbiter: s_* faces the upstream masters, m_* faces the MC.
// 'slave' is the arbiter's view, 'master' is the environment's view.
interface hawk_axird_arb_if #(
  parameter int NUM_MSTR = 2,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 4
);
  localparam int SEL_W = $clog2(NUM_MSTR);

  logic [NUM_MSTR-1:0][ID_W-1:0]   s_arid;
  logic [NUM_MSTR-1:0][ADDR_W-1:0] s_araddr;
  logic [NUM_MSTR-1:0][7:0]        s_arlen;
  logic [NUM_MSTR-1:0]             s_arvalid;
  logic [NUM_MSTR-1:0]             s_arready;
  logic [ID_W-1:0]                 s_rid;
  logic [DATA_W-1:0]               s_rdata;
  logic [1:0]                      s_rresp;
  logic                            s_rlast;
  logic [NUM_MSTR-1:0]             s_rvalid;
  logic [NUM_MSTR-1:0]             s_rready;

  logic [ID_W+SEL_W-1:0]           m_arid;
  logic [ADDR_W-1:0]               m_araddr;
  logic [7:0]                      m_arlen;
  logic                            m_arvalid;
  logic                            m_arready;
  logic [ID_W+SEL_W-1:0]           m_rid;
  logic [DATA_W-1:0]               m_rdata;
  logic [1:0]                      m_rresp;
  logic                            m_rlast;
  logic                            m_rvalid;
  logic                            m_rready;

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
           m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
           m_arid, m_araddr, m_arlen, m_arvalid, m_rready
  );

  modport master (
    output s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
           m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
           m_arid, m_araddr, m_arlen, m_arvalid, m_rready
  );

endinterface

// File: rtl/hawk_rr_arbiter.sv
// Combinational round-robin arbiter with optional single-master priority override.
module hawk_rr_arbiter
  import hacd_pkg::*;
#(
  parameter  int N     = 2,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic             prio_en,
  input  logic [SEL_W-1:0] prio_idx,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] idx
);

  // Priority master first (if requesting), otherwise first requester at or above ptr with wrap.
  always_comb begin
    logic found;
    int   j;
    found = 1'b0;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (prio_en && !found && prio_idx == SEL_W'(i) && req[i]) begin
        found = 1'b1;
        idx   = SEL_W'(i);
      end
    end
    for (int k = 0; k < N; k++) begin
      j = hawk_arb_wrap(int'(ptr) + k, N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SEL_W'(j);
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/hawk_axird_arb.sv
// N-master AXI4 read arbiter: grants AR into a one-entry output register, tags
// m_arid with the master index, steers R beats back by tag and caps in-flight bursts.
module hawk_axird_arb
  import hacd_pkg::*;
#(
  parameter  int NUM_MSTR   = 2,
  parameter  int ADDR_W     = 64,
  parameter  int DATA_W     = 512,
  parameter  int ID_W       = 4,
  parameter  int MAX_OUTSTD = 4,
  localparam int SEL_W      = $clog2(NUM_MSTR)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  hawk_axird_arb_if.slave     bus,
  input  logic                prio_mode_i,
  input  logic [SEL_W-1:0]    prio_mstr_i,
  input  logic [NUM_MSTR-1:0] mstr_block_i,
  output logic                rid_err_o,
  output logic                idle_o
);

  if (NUM_MSTR < 2 || NUM_MSTR > HAWK_ARB_MAX_MSTR) begin : g_bad_num
    $error("hawk_axird_arb: NUM_MSTR out of range");
  end
  if (MAX_OUTSTD < 1 || MAX_OUTSTD > 15) begin : g_bad_outstd
    $error("hawk_axird_arb: MAX_OUTSTD out of range");
  end

  typedef struct packed {
    logic [ID_W+SEL_W-1:0] id;
    logic [ADDR_W-1:0]     addr;
    logic [7:0]            len;
  } ar_t;

  ar_t                                        ar_q;
  logic                                       ar_vld;
  logic [SEL_W-1:0]                           rr_ptr;
  logic [NUM_MSTR-1:0][HAWK_ARB_CNT_W-1:0]    cnt;
  logic [NUM_MSTR-1:0]                        elig, gnt, ar_acc, r_done, rvld;
  logic [SEL_W-1:0]                           gidx, rsel;
  logic                                       load, rtag_ok, rrdy, prio_en;

  // A master may compete only while requesting, unblocked and below its burst cap.
  always_comb begin
    for (int i = 0; i < NUM_MSTR; i++)
      elig[i] = bus.s_arvalid[i] & ~mstr_block_i[i] &
                (cnt[i] < HAWK_ARB_CNT_W'(MAX_OUTSTD));
  end

  assign prio_en = (hawk_arb_mode_e'(prio_mode_i) == HAWK_ARB_PRIO);

  hawk_rr_arbiter #(.N(NUM_MSTR)) u_arb (
    .req      (elig),
    .prio_en  (prio_en),
    .prio_idx (prio_mstr_i),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .idx      (gidx)
  );

  // The output register takes a new AR when empty or draining this cycle.
  assign load          = ~ar_vld | bus.m_arready;
  assign ar_acc        = load ? gnt : '0;
  assign bus.s_arready = ar_acc;

  // AR output register and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_vld <= 1'b0;
      ar_q   <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      ar_vld <= |gnt;
      if (|gnt) begin
        ar_q.id   <= {gidx, bus.s_arid[gidx]};
        ar_q.addr <= bus.s_araddr[gidx];
        ar_q.len  <= bus.s_arlen[gidx];
        rr_ptr    <= SEL_W'(hawk_arb_wrap(int'(gidx) + 1, NUM_MSTR));
      end
    end
  end

  assign bus.m_arid    = ar_q.id;
  assign bus.m_araddr  = ar_q.addr;
  assign bus.m_arlen   = ar_q.len;
  assign bus.m_arvalid = ar_vld;

  // R demux by tag; an out-of-range tag is sunk so the MC never stalls on it.
  always_comb begin
    rsel    = bus.m_rid[ID_W +: SEL_W];
    rtag_ok = (int'(rsel) < NUM_MSTR);
    rvld    = '0;
    rrdy    = ~rtag_ok;
    r_done  = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      if (rtag_ok && rsel == SEL_W'(i)) begin
        rvld[i]   = bus.m_rvalid;
        rrdy      = bus.s_rready[i];
        r_done[i] = bus.m_rvalid & bus.s_rready[i] & bus.m_rlast;
      end
    end
  end

  assign bus.s_rvalid = rvld;
  assign bus.m_rready = rrdy;
  assign bus.s_rid    = bus.m_rid[ID_W-1:0];
  assign bus.s_rdata  = bus.m_rdata;
  assign bus.s_rresp  = bus.m_rresp;
  assign bus.s_rlast  = bus.m_rlast;

  // Per-master outstanding counters; simultaneous accept and completion cancel.
  for (genvar i = 0; i < NUM_MSTR; i++) begin : g_cnt
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
        cnt[i] <= '0;
      else if (ar_acc[i] && !r_done[i] && cnt[i] != '1)
        cnt[i] <= cnt[i] + HAWK_ARB_CNT_W'(1);
      else if (!ar_acc[i] && r_done[i] && cnt[i] != '0)
        cnt[i] <= cnt[i] - HAWK_ARB_CNT_W'(1);
    end
  end

  // Sticky flag for R beats carrying a tag no master owns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         rid_err_o <= 1'b0;
    else if (bus.m_rvalid && !rtag_ok)   rid_err_o <= 1'b1;
  end

  assign idle_o = ~ar_vld & (cnt == '0);

endmodule

// File: tb/tb_hawk_axird_arb.sv
// Directed bench for hawk_axird_arb with 3 masters, 32-bit address/data, 4-bit ids.
module tb_hawk_axird_arb;
  import hacd_pkg::*;

  localparam int NM = 3;

  logic       clk_i;
  logic       rst_ni;
  logic       prio_mode;
  logic [1:0] prio_mstr;
  logic [2:0] blk;
  logic       rid_err;
  logic       idle;

  int n_cmp = 0;
  int n_err = 0;

  hawk_axird_arb_if #(.NUM_MSTR(NM), .ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

  hawk_axird_arb #(
    .NUM_MSTR(NM), .ADDR_W(32), .DATA_W(32), .ID_W(4), .MAX_OUTSTD(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bus          (bus),
    .prio_mode_i  (prio_mode),
    .prio_mstr_i  (prio_mstr),
    .mstr_block_i (blk),
    .rid_err_o    (rid_err),
    .idle_o       (idle)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    bus.s_arvalid = '0;
    bus.s_rready  = '0;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    bus.m_rid     = '0;
    bus.m_rdata   = '0;
    bus.m_rresp   = '0;
    prio_mode     = 1'b0;
    prio_mstr     = '0;
    blk           = '0;
    for (int i = 0; i < NM; i++) begin
      bus.s_arid[i]   = 4'(i + 1);
      bus.s_araddr[i] = 32'h100 * (i + 1);
      bus.s_arlen[i]  = 8'(i);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clr_in();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    clr_in();
    repeat (2) tick();
    chk("rst_arvalid", bus.m_arvalid, 0);
    chk("rst_arready", bus.s_arready, 0);
    chk("rst_riderr", rid_err, 0);
    chk("rst_idle", idle, 1);
    rst_ni = 1'b1;

    // round-robin: all masters requesting, no backpressure
    bus.s_arvalid = 3'b111;
    bus.m_arready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      chk("rr_ardy", bus.s_arready, 64'(1 << (k % 3)));
      tick();
      chk("rr_tag", bus.m_arid[5:4], 64'(k % 3));
      chk("rr_id", bus.m_arid[3:0], 64'(k % 3 + 1));
    end

    // priority mode: master 2 wins over 0, then falls back; block kills grant
    do_reset();
    prio_mode = 1'b1;
    prio_mstr = 2'd2;
    bus.s_arvalid = 3'b101;
    bus.m_arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("prio_hi", bus.s_arready, 3'b100);
      tick();
      chk("prio_tag", bus.m_arid[5:4], 2);
    end
    bus.s_arvalid = 3'b001;
    @(negedge clk_i);
    chk("prio_fb", bus.s_arready, 3'b001);
    tick();
    chk("prio_fb_tag", bus.m_arid[5:4], 0);
    blk = 3'b001;
    @(negedge clk_i);
    chk("blk_ardy", bus.s_arready, 0);
    tick();
    chk("blk_arvalid", bus.m_arvalid, 0);

    // backpressure: held AR stays put while m_arready is low
    do_reset();
    bus.s_arvalid   = 3'b010;
    bus.s_arid[1]   = 4'h5;
    bus.s_araddr[1] = 32'h1000_0040;
    bus.s_arlen[1]  = 8'd3;
    tick();
    chk("bp_vld", bus.m_arvalid, 1);
    chk("bp_id", bus.m_arid, 6'h15);
    chk("bp_len", bus.m_arlen, 3);
    bus.s_araddr[1] = 32'hDEAD_0000;
    bus.s_arvalid   = 3'b011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("bp_ardy", bus.s_arready, 0);
      chk("bp_addr", bus.m_araddr, 32'h1000_0040);
      chk("bp_vld_hold", bus.m_arvalid, 1);
      tick();
    end
    bus.m_arready = 1'b1;
    @(negedge clk_i);
    chk("bp_rel_ardy", bus.s_arready, 3'b001);
    tick();
    chk("bp_rel_tag", bus.m_arid[5:4], 0);
    chk("bp_rel_vld", bus.m_arvalid, 1);

    // outstanding cap of 4 on master 1
    do_reset();
    bus.m_arready = 1'b1;
    bus.s_arvalid = 3'b010;
    bus.s_rready  = 3'b010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("cap_ardy", bus.s_arready, 3'b010);
      tick();
    end
    @(negedge clk_i);
    chk("cap_stall", bus.s_arready, 0);
    tick();
    chk("cap_stall_vld", bus.m_arvalid, 0);
    bus.m_rvalid = 1'b1;
    bus.m_rid    = 6'h10;
    bus.m_rlast  = 1'b1;
    @(negedge clk_i);
    chk("cap_rvalid", bus.s_rvalid, 3'b010);
    chk("cap_still", bus.s_arready, 0);
    tick();
    bus.m_rvalid = 1'b0;
    @(negedge clk_i);
    chk("cap_regrant", bus.s_arready, 3'b010);
    tick();
    chk("cap_regrant_vld", bus.m_arvalid, 1);

    // R routing by tag, and invalid tag handling
    do_reset();
    bus.m_arready = 1'b1;
    bus.s_arvalid = 3'b010;
    bus.s_arid[1] = 4'hA;
    tick();
    bus.s_arvalid = '0;
    tick();
    chk("r_busy", idle, 0);
    bus.m_rid     = 6'h1A;
    bus.m_rvalid  = 1'b1;
    bus.m_rlast   = 1'b1;
    bus.m_rdata   = 32'hCAFE_F00D;
    bus.s_rready  = 3'b101;
    @(negedge clk_i);
    chk("r_svalid", bus.s_rvalid, 3'b010);
    chk("r_sid", bus.s_rid, 4'hA);
    chk("r_data", bus.s_rdata, 32'hCAFE_F00D);
    chk("r_rdy_other", bus.m_rready, 0);
    tick();
    chk("r_nohs_idle", idle, 0);
    bus.s_rready = 3'b010;
    @(negedge clk_i);
    chk("r_rdy_sel", bus.m_rready, 1);
    tick();
    bus.m_rvalid = 1'b0;
    chk("r_dec_idle", idle, 1);
    bus.m_rid    = 6'h31;
    bus.m_rvalid = 1'b1;
    bus.s_rready = '0;
    @(negedge clk_i);
    chk("bad_rdy", bus.m_rready, 1);
    chk("bad_svalid", bus.s_rvalid, 0);
    chk("bad_err_pre", rid_err, 0);
    tick();
    bus.m_rvalid = 1'b0;
    chk("bad_err", rid_err, 1);
    tick();
    chk("bad_sticky", rid_err, 1);
    chk("bad_idle", idle, 1);

    // simultaneous AR accept and rlast on master 0 at count 2
    do_reset();
    bus.m_arready = 1'b1;
    bus.s_rready  = 3'b001;
    bus.s_arvalid = 3'b001;
    tick();
    tick();
    bus.m_rid    = 6'h00;
    bus.m_rlast  = 1'b1;
    bus.m_rvalid = 1'b1;
    @(negedge clk_i);
    chk("sim_ardy", bus.s_arready, 3'b001);
    chk("sim_rrdy", bus.m_rready, 1);
    tick();
    bus.s_arvalid = '0;
    tick();
    chk("sim_cnt1_idle", idle, 0);
    tick();
    bus.m_rvalid = 1'b0;
    chk("sim_cnt0_idle", idle, 1);

    // asynchronous reset in the middle of a burst
    bus.s_arvalid = 3'b001;
    tick();
    bus.s_arvalid = '0;
    chk("mid_busy", idle, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_vld", bus.m_arvalid, 0);
    tick();
    rst_ni = 1'b1;
    bus.m_rid    = 6'h00;
    bus.m_rlast  = 1'b1;
    bus.m_rvalid = 1'b1;
    tick();
    bus.m_rvalid = 1'b0;
    chk("mid_ok_err", rid_err, 0);
    chk("mid_ok_idle", idle, 1);
    bus.m_rid    = 6'h31;
    bus.m_rvalid = 1'b1;
    tick();
    bus.m_rvalid = 1'b0;
    chk("mid_bad_err", rid_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
